// File: rtl/seven_segment_scan_controller_if.sv
// seven_segment_scan_controller_if: digit data bus with load/ack shadow-update handshake
interface seven_segment_scan_controller_if #(
   parameter int NUM_DIGITS = 4
);
   logic [4*NUM_DIGITS-1:0] digit_data;
   logic [NUM_DIGITS-1:0]   dp_data;
   logic [NUM_DIGITS-1:0]   digit_mask;
   logic                    load;
   logic                    load_ack;
   modport master (output digit_data, dp_data, digit_mask, load, input load_ack);
   modport slave (input digit_data, dp_data, digit_mask, load, output load_ack);
endinterface

// File: rtl/seven_segment_scan_controller.sv
// seven_segment_scan_controller: blanked digit scanner with frame-synchronous shadow loads
module seven_segment_scan_controller #(
   parameter int NUM_DIGITS = 4,
   parameter int BLANK_CYCLES = 2,
   parameter bit ANODE_ACTIVE_LOW = 1'b1,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             scan_tick,
   input  logic                             enable,
   seven_segment_scan_controller_if.slave   bus,
   output logic [NUM_DIGITS-1:0]            anode,
   output logic [6:0]                       segments,
   output logic                             dp,
   output logic                             frame_done,
   output logic [IW-1:0]                    current_digit
);
   localparam int BW = $clog2(BLANK_CYCLES) + 1;
   localparam logic [6:0] HEX [0:15] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                         7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
   typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;
   state_t                  state, state_n;
   logic [2:0]              sync;
   logic [BW-1:0]           cnt, cnt_n;
   logic [IW-1:0]           idx_n;
   logic [4*NUM_DIGITS-1:0] data_sh, data_n;
   logic [NUM_DIGITS-1:0]   dp_sh, dp_n, mask_sh, mask_n, an_on;
   logic [6:0]              seg_on;
   logic                    pending, step, last, blank_done, wrap, cap, lit;
   // any tick transition is one scan step
   assign step = sync[1] ^ sync[2];
   assign last = current_digit == IW'(NUM_DIGITS - 1);
   assign blank_done = cnt == BW'(BLANK_CYCLES - 1);
   assign wrap = enable && state == DRIVE && step && last;
   assign cap = (bus.load || pending) && (wrap || state == IDLE);
   assign data_n = cap ? bus.digit_data : data_sh;
   assign dp_n = cap ? bus.dp_data : dp_sh;
   assign mask_n = cap ? bus.digit_mask : mask_sh;
   always_comb begin
      state_n = state;
      idx_n = current_digit;
      cnt_n = '0;
      if (!enable) begin
         state_n = IDLE;
         idx_n = '0;
      end else if (state == IDLE) begin
         state_n = step ? BLANK : IDLE;
         idx_n = '0;
      end else if (state == BLANK) begin
         state_n = blank_done ? DRIVE : BLANK;
         cnt_n = blank_done ? '0 : cnt + BW'(1);
      end else if (step) begin
         state_n = BLANK;
         idx_n = last ? '0 : current_digit + IW'(1);
      end
   end
   // pins are registered from next-state values so they track the state register exactly
   assign lit = state_n != IDLE;
   assign seg_on = lit ? HEX[data_n[{idx_n, 2'b00} +: 4]] : 7'h00;
   assign an_on = state_n == DRIVE && mask_n[idx_n] ? NUM_DIGITS'(1) << idx_n : '0;
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
         current_digit <= '0;
         cnt <= '0;
         sync <= '0;
         pending <= 1'b0;
         data_sh <= '0;
         dp_sh <= '0;
         mask_sh <= '0;
         bus.load_ack <= 1'b0;
         frame_done <= 1'b0;
         anode <= {NUM_DIGITS{ANODE_ACTIVE_LOW}};
         segments <= {7{SEG_ACTIVE_LOW}};
         dp <= SEG_ACTIVE_LOW;
      end else begin
         state <= state_n;
         current_digit <= idx_n;
         cnt <= cnt_n;
         sync <= {sync[1:0], scan_tick};
         pending <= (bus.load || pending) && !cap;
         data_sh <= data_n;
         dp_sh <= dp_n;
         mask_sh <= mask_n;
         bus.load_ack <= cap;
         frame_done <= wrap;
         anode <= an_on ^ {NUM_DIGITS{ANODE_ACTIVE_LOW}};
         segments <= seg_on ^ {7{SEG_ACTIVE_LOW}};
         dp <= (lit && dp_n[idx_n]) ^ SEG_ACTIVE_LOW;
      end
   end
endmodule

// File: tb/tb_seven_segment_scan_controller.sv
// tb_seven_segment_scan_controller: scoreboard bench; expected output changes queued, monitor pops on each change
module tb_seven_segment_scan_controller;
   localparam int N = 4;
   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         scan_tick = 1'b0;
   logic         enable = 1'b1;
   logic [N-1:0] anode;
   logic [6:0]   segments;
   logic         dp, frame_done;
   logic [1:0]   current_digit;
   int           checks = 0;
   int           errors = 0;
   seven_segment_scan_controller_if #(.NUM_DIGITS(N)) bif ();
   seven_segment_scan_controller #(.NUM_DIGITS(N)) dut (
      .clk(clk), .reset(reset), .scan_tick(scan_tick), .enable(enable), .bus(bif),
      .anode(anode), .segments(segments), .dp(dp), .frame_done(frame_done),
      .current_digit(current_digit)
   );
   always #5 clk = ~clk;
   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
      logic       ack;
      logic       fd;
      logic [1:0] cd;
   } vec_t;
   typedef struct {
      vec_t  v;
      int    dur;
      string name;
   } exp_t;
   exp_t q[$];
   task automatic push(input string name, input logic [3:0] an, input logic [6:0] seg,
                       input logic d, input logic a, input logic f, input logic [1:0] cd, input int dur);
      exp_t e;
      e.v = {an, seg, d, a, f, cd};
      e.dur = dur;
      e.name = name;
      q.push_back(e);
   endtask
   // one scan slot: 2 dark cycles then 6 driven cycles with the digit's anode low
   task automatic slot(input string name, input logic [6:0] seg, input logic d, input logic [1:0] cd);
      logic [3:0] one = 4'b0001;
      push({name, " blank"}, 4'hF, seg, d, 1'b0, 1'b0, cd, 2);
      push({name, " drive"}, ~(one << cd), seg, d, 1'b0, 1'b0, cd, 6);
   endtask
   task automatic wrap(input string name, input logic [6:0] seg, input logic a);
      push({name, " fd"}, 4'hF, seg, 1'b1, a, 1'b1, 2'd0, 1);
      push({name, " blank"}, 4'hF, seg, 1'b1, 1'b0, 1'b0, 2'd0, 1);
      push({name, " drive"}, 4'hE, seg, 1'b1, 1'b0, 1'b0, 2'd0, 6);
   endtask
   task automatic toggle();
      scan_tick = ~scan_tick;
      repeat (8) @(negedge clk);
   endtask
   task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] m);
      bif.digit_data = d;
      bif.dp_data = p;
      bif.digit_mask = m;
      bif.load = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (bif.load_ack) break;
      end
      checks++;
      if (!bif.load_ack) begin
         errors++;
         $display("FAIL load_ack timeout: got 0, expected 1");
      end
      bif.load = 1'b0;
   endtask
   // monitor: every change of the output vector pops one expectation; hold time checked at next change
   initial begin
      vec_t cur, prev;
      exp_t hold;
      int   held;
      bit   have;
      prev = 'x;
      held = 0;
      have = 1'b0;
      forever begin
         @(negedge clk);
         cur = {anode, segments, dp, bif.load_ack, frame_done, current_digit};
         if (cur !== prev) begin
            if (have && hold.dur != 0) begin
               checks++;
               if (held != hold.dur) begin
                  errors++;
                  $display("FAIL %s duration: got %0d cycles, expected %0d", hold.name, held, hold.dur);
               end
            end
            checks++;
            if (q.size() == 0) begin
               errors++;
               have = 1'b0;
               $display("FAIL unexpected change: got %h, expected no change", cur);
            end else begin
               hold = q.pop_front();
               have = 1'b1;
               if (cur !== hold.v) begin
                  errors++;
                  $display("FAIL %s: got an=%h seg=%h dp=%b ack=%b fd=%b cd=%0d, expected an=%h seg=%h dp=%b ack=%b fd=%b cd=%0d",
                           hold.name, cur.an, cur.seg, cur.dp, cur.ack, cur.fd, cur.cd,
                           hold.v.an, hold.v.seg, hold.v.dp, hold.v.ack, hold.v.fd, hold.v.cd);
               end
            end
            held = 1;
            prev = cur;
         end else begin
            held++;
         end
      end
   end
   initial begin
      bif.load = 1'b0;
      bif.digit_data = '0;
      bif.dp_data = '0;
      bif.digit_mask = '0;
      push("reset", 4'hF, 7'h7F, 1'b1, 1'b0, 1'b0, 2'd0, 5);
      push("t2 ack", 4'hF, 7'h7F, 1'b1, 1'b1, 1'b0, 2'd0, 1);
      push("t2 idle", 4'hF, 7'h7F, 1'b1, 1'b0, 1'b0, 2'd0, 3);
      slot("t2 d0", 7'h19, 1'b1, 2'd0);
      slot("t3 d1", 7'h30, 1'b0, 2'd1);
      slot("t3 d2", 7'h24, 1'b1, 2'd2);
      slot("t3 d3", 7'h79, 1'b1, 2'd3);
      wrap("t3 wrap", 7'h19, 1'b0);
      slot("t4 d1", 7'h30, 1'b0, 2'd1);
      slot("t4 d2", 7'h24, 1'b1, 2'd2);
      slot("t4 d3", 7'h79, 1'b1, 2'd3);
      wrap("t4 wrap", 7'h21, 1'b1);
      slot("abcd d1", 7'h46, 1'b1, 2'd1);
      slot("abcd d2", 7'h03, 1'b1, 2'd2);
      slot("abcd d3", 7'h08, 1'b0, 2'd3);
      wrap("abcd wrap", 7'h21, 1'b1);
      slot("t5 d1", 7'h46, 1'b1, 2'd1);
      push("t5 d2 masked", 4'hF, 7'h03, 1'b1, 1'b0, 1'b0, 2'd2, 8);
      slot("t5 d3", 7'h08, 1'b0, 2'd3);
      wrap("t5 wrap", 7'h21, 1'b1);
      slot("t6 d1", 7'h46, 1'b1, 2'd1);
      slot("t6 d2", 7'h03, 1'b1, 2'd2);
      push("t6 dark", 4'hF, 7'h7F, 1'b1, 1'b0, 1'b0, 2'd0, 6);
      push("t6 restart blank", 4'hF, 7'h21, 1'b1, 1'b0, 1'b0, 2'd0, 2);
      push("t6 restart drive", 4'hE, 7'h21, 1'b1, 1'b0, 1'b0, 2'd0, 0);
      repeat (4) begin
         @(negedge clk);
         scan_tick = ~scan_tick;
      end
      @(negedge clk);
      reset = 1'b1;
      enable = 1'b0;
      do_load(16'h1234, 4'b0010, 4'hF);
      @(negedge clk);
      enable = 1'b1;
      repeat (5) toggle();
      toggle();
      fork
         do_load(16'hABCD, 4'b1000, 4'hF);
      join_none
      repeat (3) toggle();
      fork
         do_load(16'hABCD, 4'b1000, 4'b1011);
      join_none
      repeat (4) toggle();
      fork
         do_load(16'hABCD, 4'b1000, 4'hF);
      join_none
      repeat (4) toggle();
      repeat (2) toggle();
      scan_tick = ~scan_tick;
      repeat (2) @(negedge clk);
      enable = 1'b0;
      repeat (4) @(negedge clk);
      enable = 1'b1;
      scan_tick = ~scan_tick;
      repeat (12) @(negedge clk);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard drain: got %0d pending, expected 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
